pmc_bus_arbiter: RTL and testbench

Shares the single PMC slave register port (offset-decoded req/gnt/rvalid interface) between NUM_MASTERS bus masters, e.g. core data port and debug module. Round-robin arbitration, one outstanding transaction at a time, response routed back to the owning master. Unmapped addresses, which the slave never grants, are terminated by a timeout that returns an error response, so no master can hang the bus.

---
 rtl/pmc_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_pmc_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pmc_bus_arbiter.sv
// Round-robin arbiter sharing the PMC slave register port between bus masters.
// One transaction in flight; requests the slave never grants are ended by a timeout error response.
module pmc_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  output logic [31:0]               m_rdata,
  output logic                      m_err,
  output logic                      s_req,
  output logic                      s_we,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  input  logic                      s_gnt,
  input  logic                      s_rvalid,
  input  logic [31:0]               s_rdata
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] prev_sel;
  logic [CW-1:0] cnt;

  logic [PW-1:0] sel;
  logic [PW-1:0] sel_next_ptr;
  logic          any_req;
  logic          slave_gnt;
  logic          timeout_hit;
  logic [CW-1:0] cnt_eff;

  always_comb begin : p_sel
    logic [PW:0] idx;
    sel     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_MASTERS)) idx = idx - (PW+1)'(NUM_MASTERS);
      if (!any_req && m_req[idx[PW-1:0]]) begin
        any_req = 1'b1;
        sel     = idx[PW-1:0];
      end
    end
  end

  // cnt is zero after any cycle that was not an ungranted wait, so only a sel change needs masking
  assign cnt_eff      = (sel == prev_sel) ? cnt : '0;
  assign slave_gnt    = any_req && s_gnt;
  assign timeout_hit  = (state == ST_IDLE) && any_req && !s_gnt && (cnt_eff == CW'(TIMEOUT-1));
  assign sel_next_ptr = (sel == PW'(NUM_MASTERS-1)) ? '0 : sel + PW'(1);

  // Outputs are forced to zero while reset is held
  always_comb begin
    m_gnt    = '0;
    m_rvalid = '0;
    m_rdata  = '0;
    m_err    = 1'b0;
    s_req    = 1'b0;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    if (rst_n) begin
      case (state)
        ST_IDLE: begin
          s_req = any_req;
          if (any_req) begin
            s_we       = m_we[sel];
            s_addr     = m_addr[sel*32 +: 32];
            s_wdata    = m_wdata[sel*32 +: 32];
            m_gnt[sel] = s_gnt || timeout_hit;
          end
        end
        ST_BUSY: begin
          if (s_rvalid) begin
            m_rvalid[owner] = 1'b1;
            m_rdata         = s_rdata;
          end
        end
        ST_ERR: begin
          m_rvalid[owner] = 1'b1;
          m_err           = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      prev_sel <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          prev_sel <= sel;
          if (slave_gnt || timeout_hit) begin
            owner  <= sel;
            rr_ptr <= sel_next_ptr;
            cnt    <= '0;
            state  <= slave_gnt ? ST_BUSY : ST_ERR;
          end else if (any_req) begin
            cnt <= cnt_eff + CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_BUSY: if (s_rvalid) state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmc_bus_arbiter.sv
// Bench for pmc_bus_arbiter: directed vector table, hand sequences for timeout corners,
// then randomized traffic compared against a transaction-level reference model.
module tb_pmc_bus_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  m_req, m_we;
  logic [N*32-1:0] m_addr, m_wdata;
  logic [N-1:0]  m_gnt, m_rvalid;
  logic [31:0]   m_rdata;
  logic          m_err;
  logic          s_req, s_we;
  logic [31:0]   s_addr, s_wdata;
  logic          s_gnt, s_rvalid;
  logic [31:0]   s_rdata;

  int errors = 0;
  int checks = 0;

  pmc_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] a0, a1, d0, d1;
    logic        sg, sv;
    logic [31:0] sr;
    logic [1:0]  e_gnt, e_rv;
    logic [31:0] e_rd;
    logic        e_err, e_sreq, e_swe;
    logic [31:0] e_sa, e_sd;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic [1:0] req, input logic [1:0] we,
    input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
    input logic sg, input logic sv, input logic [31:0] sr,
    input logic [1:0] e_gnt, input logic [1:0] e_rv, input logic [31:0] e_rd, input logic e_err,
    input logic e_sreq, input logic e_swe, input logic [31:0] e_sa, input logic [31:0] e_sd);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.sg = sg; v.sv = sv; v.sr = sr; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_err = e_err; v.e_sreq = e_sreq; v.e_swe = e_swe; v.e_sa = e_sa; v.e_sd = e_sd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0,
                       input logic [31:0] d1, input logic sg, input logic sv, input logic [31:0] sr);
    rst_n = rst; m_req = req; m_we = we; m_addr = {a1, a0}; m_wdata = {d1, d0};
    s_gnt = sg; s_rvalid = sv; s_rdata = sr;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.rst, v.req, v.we, v.a0, v.a1, v.d0, v.d1, v.sg, v.sv, v.sr);
    #1;
    chk({tag, ".m_gnt"},    32'(m_gnt),    32'(v.e_gnt));
    chk({tag, ".m_rvalid"}, 32'(m_rvalid), 32'(v.e_rv));
    chk({tag, ".m_rdata"},  m_rdata,       v.e_rd);
    chk({tag, ".m_err"},    32'(m_err),    32'(v.e_err));
    chk({tag, ".s_req"},    32'(s_req),    32'(v.e_sreq));
    chk({tag, ".s_we"},     32'(s_we),     32'(v.e_swe));
    chk({tag, ".s_addr"},   s_addr,        v.e_sa);
    chk({tag, ".s_wdata"},  s_wdata,       v.e_sd);
  endtask

  vec_t tbl[20];

  // Reference model state: who is awaiting a response, whether an error reply is due,
  // the round-robin start point and the current uninterrupted wait.
  int  ref_owner;
  bit  ref_busy, ref_errp;
  int  ref_rr, ref_wait_who, ref_waited;

  initial begin
    drive(1'b0, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 0);

    // Directed sequence; each row is one clock cycle.
    tbl[0]  = mk(0, 2'b11, 2'b00, 32'h10, 32'h20, 32'h1, 32'h2, 1, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2'b01, 2'b00, 32'h10, 32'hDEAD_0000, 0, 32'hFFFF_FFFF, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 32'h10, 0);
    tbl[2]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'hA5A5_0001,                  2'b00, 2'b01, 32'hA5A5_0001, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 2'b01, 2'b11, 32'h20, 32'hDEAD_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1, 0, 0,
                 2'b01, 2'b00, 0, 0, 1, 1, 32'h20, 32'h1234_5678);
    tbl[4]  = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D,                  2'b00, 2'b01, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 0, 0,    2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 0, 0,    2'b01, 2'b00, 0, 0, 1, 0, 32'h100, 32'h1111);
    tbl[7]  = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 1, 32'h1, 2'b00, 2'b01, 32'h1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 0, 0,    2'b10, 2'b00, 0, 0, 1, 1, 32'h200, 32'h2222);
    tbl[9]  = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 1, 32'h2, 2'b00, 2'b10, 32'h2, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 0, 0,    2'b01, 2'b00, 0, 0, 1, 0, 32'h100, 32'h1111);
    tbl[11] = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 1, 32'h3, 2'b00, 2'b01, 32'h3, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 0, 0,    2'b10, 2'b00, 0, 0, 1, 1, 32'h200, 32'h2222);
    tbl[13] = mk(1, 2'b11, 2'b10, 32'h100, 32'h200, 32'h1111, 32'h2222, 1, 1, 32'h4, 2'b00, 2'b10, 32'h4, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h55,                         2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 2'b01, 2'b00, 32'h30, 32'h40, 0, 0, 1, 0, 0,                    2'b01, 2'b00, 0, 0, 1, 0, 32'h30, 0);
    tbl[16] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h66,                         2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h77,                         2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 2'b11, 2'b00, 32'h30, 32'h40, 0, 0, 1, 0, 0,                    2'b01, 2'b00, 0, 0, 1, 0, 32'h30, 0);
    tbl[19] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h88,                         2'b00, 2'b01, 32'h88, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Unmapped address from master 1 (rr_ptr is 1 here): error grant at cycle TO-1, reply at TO.
    for (int k = 0; k < TO - 1; k++)
      apply_vec(mk(1, 2'b10, 2'b00, 0, 32'hFFFF_0000, 0, 0, 0, 0, 0,
                   2'b00, 2'b00, 0, 0, 1, 0, 32'hFFFF_0000, 0), $sformatf("to_wait%0d", k));
    apply_vec(mk(1, 2'b10, 2'b00, 0, 32'hFFFF_0000, 0, 0, 0, 0, 0,
                 2'b10, 2'b00, 0, 0, 1, 0, 32'hFFFF_0000, 0), "to_gnt");
    apply_vec(mk(1, 2'b10, 2'b00, 0, 32'hFFFF_0000, 0, 0, 0, 1, 32'hBEEF,
                 2'b00, 2'b10, 0, 1, 0, 0, 0, 0), "to_err");
    apply_vec(mk(1, 2'b11, 2'b00, 32'h50, 32'h60, 0, 0, 1, 0, 0,
                 2'b01, 2'b00, 0, 0, 1, 0, 32'h50, 0), "to_rr_next");
    apply_vec(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'h9, 2'b00, 2'b01, 32'h9, 0, 0, 0, 0, 0), "to_rr_resp");

    // Preempted wait: bring rr_ptr to 0 with a master 1 transaction first.
    apply_vec(mk(1, 2'b10, 2'b00, 0, 32'h60, 0, 0, 1, 0, 0, 2'b10, 2'b00, 0, 0, 1, 0, 32'h60, 0), "pre_g1");
    apply_vec(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'hA, 2'b00, 2'b10, 32'hA, 0, 0, 0, 0, 0), "pre_r1");
    for (int k = 0; k < 5; k++)
      apply_vec(mk(1, 2'b10, 2'b00, 32'h70, 32'h60, 0, 0, 0, 0, 0,
                   2'b00, 2'b00, 0, 0, 1, 0, 32'h60, 0), $sformatf("pre_m1_%0d", k));
    for (int k = 0; k < TO - 2; k++)
      apply_vec(mk(1, 2'b11, 2'b00, 32'h70, 32'h60, 0, 0, 0, 0, 0,
                   2'b00, 2'b00, 0, 0, 1, 0, 32'h70, 0), $sformatf("pre_m0_%0d", k));
    apply_vec(mk(1, 2'b11, 2'b00, 32'h70, 32'h60, 0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 1, 0, 32'h70, 0), "pre_gnt0");
    apply_vec(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 32'hB, 2'b00, 2'b01, 32'hB, 0, 0, 0, 0, 0), "pre_resp0");

    // Randomized traffic against the reference model, starting from a reset.
    begin
      logic        rst, sg, sv, any, to;
      logic [1:0]  req, we, e_gnt, e_rv;
      logic [31:0] a0, a1, d0, d1, sr, e_rd, e_sa, e_sd;
      logic        e_err, e_sreq, e_swe;
      int          pick, weff;
      bit          unmapped;
      req = 2'b00; we = 2'b00; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      ref_busy = 0; ref_errp = 0; ref_owner = 0; ref_rr = 0; ref_wait_who = -1; ref_waited = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        unmapped = ((cyc / 60) % 3) == 2;
        rst = (cyc == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, unmapped ? 29 : 4) == 0) begin
          req = 2'($urandom_range(0, 3));
          we  = 2'($urandom_range(0, 3));
          a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
        end
        sg = unmapped ? 1'b0 : ($urandom_range(0, 2) == 0);
        sv = $urandom_range(0, 1) == 1;
        sr = $urandom;

        e_gnt = 0; e_rv = 0; e_rd = 0; e_err = 0; e_sreq = 0; e_swe = 0; e_sa = 0; e_sd = 0;
        any = 0; to = 0; pick = 0; weff = 0;
        if (rst) begin
          if (ref_busy) begin
            if (sv) begin e_rv[ref_owner] = 1'b1; e_rd = sr; end
          end else if (ref_errp) begin
            e_rv[ref_owner] = 1'b1; e_err = 1'b1;
          end else begin
            for (int j = 0; j < N; j++)
              if (!any && req[(ref_rr + j) % N]) begin any = 1; pick = (ref_rr + j) % N; end
            if (any) begin
              e_sreq = 1'b1;
              e_swe  = we[pick];
              e_sa   = (pick == 0) ? a0 : a1;
              e_sd   = (pick == 0) ? d0 : d1;
              weff   = (pick == ref_wait_who) ? ref_waited : 0;
              to     = !sg && (weff == TO - 1);
              if (sg || to) e_gnt[pick] = 1'b1;
            end
          end
        end

        apply_vec(mk(rst, req, we, a0, a1, d0, d1, sg, sv, sr,
                     e_gnt, e_rv, e_rd, e_err, e_sreq, e_swe, e_sa, e_sd), $sformatf("rnd%0d", cyc));

        if (!rst) begin
          ref_busy = 0; ref_errp = 0; ref_owner = 0; ref_rr = 0; ref_wait_who = -1; ref_waited = 0;
        end else if (ref_busy) begin
          if (sv) ref_busy = 0;
        end else if (ref_errp) begin
          ref_errp = 0;
        end else if (any && (sg || to)) begin
          ref_busy = sg; ref_errp = !sg; ref_owner = pick;
          ref_rr = (pick + 1) % N; ref_wait_who = -1; ref_waited = 0;
        end else if (any) begin
          ref_wait_who = pick; ref_waited = weff + 1;
        end else begin
          ref_wait_who = -1; ref_waited = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
